mac_kbd_host: RTL and testbench

//  Host (Mac-side) initiator for the M0110 keyboard command/response link; drives the keyboard

---
 rtl/mac_kbd_host.sv | 170 +++++++++++++++++
 tb/tb_mac_kbd_host.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_kbd_host.sv
// Host-side initiator for the M0110 keyboard command/response link: resyncs with Model,
// polls with Inquiry, expands 0x79 keypad prefixes via Instant and runs Test on request.
module mac_kbd_host #(
  parameter logic [15:0] POLL_GAP  = 16'h0100,
  parameter logic [21:0] TIMEOUT   = 22'h180000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [7:0] cmd_data,
  output logic       cmd_strobe,
  input  logic [7:0] rsp_data,
  input  logic       rsp_strobe,
  input  logic       test_req,
  output logic       key_strobe,
  output logic [6:0] key_code,
  output logic       key_up,
  output logic       key_keypad,
  output logic [7:0] model_id,
  output logic       model_valid,
  output logic       test_done,
  output logic       test_pass,
  output logic       timeout_err
);

  localparam logic [7:0] CMD_MODEL   = 8'h16;
  localparam logic [7:0] CMD_INSTANT = 8'h14;
  localparam logic [7:0] CMD_TEST    = 8'h36;
  localparam logic [7:0] CMD_INQUIRY = 8'h10;
  localparam logic [7:0] RSP_PREFIX  = 8'h79;
  localparam logic [7:0] RSP_NULL    = 8'h7B;
  localparam logic [7:0] RSP_PASS    = 8'h7D;

  typedef enum logic [1:0] {GAP, SEND, WAIT} state_t;
  typedef enum logic [1:0] {OP_MODEL, OP_INSTANT, OP_TEST, OP_INQUIRY} op_t;

  state_t      state;
  op_t         op;
  op_t         next_op;
  logic [7:0]  next_cmd;
  logic [15:0] gap;
  logic [21:0] tmo;
  logic [1:0]  retry;
  logic        resync;
  logic        prefix;
  logic        test_pend;

  // Command priority: resync, then keypad expansion, then a pending test, else a plain poll.
  always_comb begin
    next_op  = OP_INQUIRY;
    next_cmd = CMD_INQUIRY;
    if (resync) begin
      next_op  = OP_MODEL;
      next_cmd = CMD_MODEL;
    end else if (prefix) begin
      next_op  = OP_INSTANT;
      next_cmd = CMD_INSTANT;
    end else if (test_pend) begin
      next_op  = OP_TEST;
      next_cmd = CMD_TEST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= GAP;
      op          <= OP_MODEL;
      gap         <= 16'd0;
      tmo         <= 22'd0;
      retry       <= 2'd0;
      resync      <= 1'b1;
      prefix      <= 1'b0;
      test_pend   <= 1'b0;
      cmd_data    <= 8'h00;
      cmd_strobe  <= 1'b0;
      key_strobe  <= 1'b0;
      key_code    <= 7'd0;
      key_up      <= 1'b0;
      key_keypad  <= 1'b0;
      model_id    <= 8'h00;
      model_valid <= 1'b0;
      test_done   <= 1'b0;
      test_pass   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_strobe  <= 1'b0;
      key_strobe  <= 1'b0;
      test_done   <= 1'b0;
      timeout_err <= 1'b0;
      if (ce) begin
        if (state == SEND && next_op == OP_TEST)
          test_pend <= 1'b0;
        else
          test_pend <= test_pend | test_req;

        case (state)
          GAP: begin
            if (gap >= POLL_GAP - 16'd1) begin
              gap   <= 16'd0;
              state <= SEND;
            end else begin
              gap <= gap + 16'd1;
            end
          end

          SEND: begin
            op         <= next_op;
            cmd_data   <= next_cmd;
            cmd_strobe <= 1'b1;
            tmo        <= 22'd0;
            state      <= WAIT;
          end

          WAIT: begin
            // A reply arriving on the final timeout cycle still counts as a reply.
            if (rsp_strobe) begin
              retry <= 2'd0;
              gap   <= 16'd0;
              state <= GAP;
              case (op)
                OP_MODEL: begin
                  model_id    <= rsp_data;
                  model_valid <= 1'b1;
                  resync      <= 1'b0;
                end
                OP_TEST: begin
                  test_pass <= (rsp_data == RSP_PASS);
                  test_done <= 1'b1;
                end
                default: begin
                  if (op == OP_INQUIRY && rsp_data == RSP_PREFIX) begin
                    prefix <= 1'b1;
                  end else if (rsp_data == RSP_PREFIX || rsp_data == RSP_NULL) begin
                    prefix <= 1'b0;
                  end else begin
                    key_strobe <= 1'b1;
                    key_code   <= rsp_data[6:0];
                    key_up     <= rsp_data[7];
                    key_keypad <= prefix;
                    prefix     <= 1'b0;
                  end
                end
              endcase
            end else if (tmo >= TIMEOUT - 22'd1) begin
              timeout_err <= 1'b1;
              prefix      <= 1'b0;
              tmo         <= TIMEOUT;
              gap         <= 16'd0;
              state       <= GAP;
              // Too many silent polls in a row means the keyboard lost sync: re-identify it.
              if ({1'b0, retry} + 3'd1 >= {1'b0, MAX_RETRY}) begin
                retry       <= 2'd0;
                model_valid <= 1'b0;
                resync      <= 1'b1;
              end else begin
                retry <= retry + 2'd1;
              end
            end else begin
              tmo <= tmo + 22'd1;
            end
          end

          default: state <= GAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_kbd_host.sv
// Randomized bench for mac_kbd_host: a keyboard responder with a behavioural model feeds an
// expected-event queue that an independent monitor drains against the DUT outputs.
module tb_mac_kbd_host;

  localparam int P = 20;
  localparam int T = 50;

  logic       clk;
  logic       reset;
  logic       ce;
  logic [7:0] cmd_data;
  logic       cmd_strobe;
  logic [7:0] rsp_data;
  logic       rsp_strobe;
  logic       test_req;
  logic       key_strobe;
  logic [6:0] key_code;
  logic       key_up;
  logic       key_keypad;
  logic [7:0] model_id;
  logic       model_valid;
  logic       test_done;
  logic       test_pass;
  logic       timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_end = 0;

  logic [31:0] exp_q[$];

  bit         m_resync;
  bit         m_prefix;
  bit         m_tpend;
  int         m_fails;
  bit         m_mvalid;
  logic [7:0] m_mid;
  bit         m_pass;

  mac_kbd_host #(.POLL_GAP(16'd20), .TIMEOUT(22'd50), .MAX_RETRY(2'd3)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
    .rsp_data(rsp_data), .rsp_strobe(rsp_strobe),
    .test_req(test_req),
    .key_strobe(key_strobe), .key_code(key_code), .key_up(key_up), .key_keypad(key_keypad),
    .model_id(model_id), .model_valid(model_valid),
    .test_done(test_done), .test_pass(test_pass), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event signature: kind 0=command, 1=key, 2=test, 3=timeout.
  function automatic logic [31:0] sig(input int kind, input logic [7:0] a, input logic b,
                                      input logic c);
    logic [7:0] k;
    k = kind[7:0];
    return {k, a, 14'd0, b, c};
  endfunction

  function automatic logic [7:0] model_cmd();
    if (m_resync) return 8'h16;
    if (m_prefix) return 8'h14;
    if (m_tpend)  return 8'h36;
    return 8'h10;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_resync = 1; m_prefix = 0; m_tpend = 0; m_fails = 0;
    m_mvalid = 0; m_mid = 8'h00; m_pass = 0;
  endtask

  task automatic mon_pop(input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_event", act, 32'hFFFF_FFFF);
    end else begin
      checkOutput("event", act, exp_q.pop_front());
    end
  endtask

  // Monitor: every DUT pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (key_strobe)  mon_pop(sig(1, {1'b0, key_code}, key_up, key_keypad));
      if (test_done)   mon_pop(sig(2, 8'h00, test_pass, 1'b0));
      if (timeout_err) mon_pop(sig(3, 8'h00, 1'b0, 1'b0));
      if (cmd_strobe)  mon_pop(sig(0, cmd_data, 1'b0, 1'b0));
    end
  end

  task automatic wait_cmd(output bit got);
    got = 0;
    for (int n = 0; n < P + T + 20 && !got; n++) begin
      @(negedge clk);
      if (cmd_strobe) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL cmd_wait: got no cmd_strobe expected one within %0d cycles", P + T + 20);
    end
  endtask

  // One keyboard transaction: answer the next command (or stay silent) and predict the outcome.
  task automatic applyStimulus(input bit reply, input logic [7:0] data, input int delay,
                               input bit req_test, input bit gap_noise);
    bit got;
    logic [7:0] cur;
    wait_cmd(got);
    if (!got) return;
    checkOutput("gap_len", cyc - last_end, P + 1);
    cur = model_cmd();
    if (cur == 8'h36) m_tpend = 0;
    if (req_test) m_tpend = 1;
    test_req = req_test;
    if (reply) begin
      case (cur)
        8'h16: begin m_mid = data; m_mvalid = 1; m_resync = 0; end
        8'h36: begin m_pass = (data == 8'h7D); exp_q.push_back(sig(2, 8'h00, m_pass, 1'b0)); end
        8'h10: begin
          if (data == 8'h79) m_prefix = 1;
          else if (data != 8'h7B) exp_q.push_back(sig(1, {1'b0, data[6:0]}, data[7], 1'b0));
        end
        default: begin
          if (data != 8'h79 && data != 8'h7B)
            exp_q.push_back(sig(1, {1'b0, data[6:0]}, data[7], 1'b1));
          m_prefix = 0;
        end
      endcase
      m_fails = 0;
      exp_q.push_back(sig(0, model_cmd(), 1'b0, 1'b0));
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        test_req = 0;
      end
      rsp_data = data;
      rsp_strobe = 1;
      @(posedge clk);
      #1;
      rsp_strobe = 0;
      test_req = 0;
      @(negedge clk);
      last_end = cyc;
      checkOutput("model_valid", {31'd0, model_valid}, {31'd0, m_mvalid});
      checkOutput("model_id", {24'd0, model_id}, {24'd0, m_mid});
      checkOutput("test_pass", {31'd0, test_pass}, {31'd0, m_pass});
    end else begin
      exp_q.push_back(sig(3, 8'h00, 1'b0, 1'b0));
      m_prefix = 0;
      m_fails++;
      if (m_fails >= 3) begin
        m_fails = 0;
        m_mvalid = 0;
        m_resync = 1;
      end
      exp_q.push_back(sig(0, model_cmd(), 1'b0, 1'b0));
      for (int i = 0; i < T; i++) begin
        @(negedge clk);
        test_req = 0;
      end
      checkOutput("tmo_pulse", {31'd0, timeout_err}, 32'd1);
      last_end = cyc;
      checkOutput("model_valid", {31'd0, model_valid}, {31'd0, m_mvalid});
    end
    if (gap_noise) begin
      @(negedge clk);
      @(negedge clk);
      rsp_data = 8'h1D;
      rsp_strobe = 1;
      @(posedge clk);
      #1;
      rsp_strobe = 0;
    end
  endtask

  function automatic logic [30:0] all_outputs();
    return {cmd_data, cmd_strobe, key_strobe, key_code, key_up, key_keypad,
            model_id, model_valid, test_done, test_pass, timeout_err};
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    logic [7:0] d;
    int r;
    reset = 1; ce = 1; rsp_data = 8'h00; rsp_strobe = 0; test_req = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {1'b0, all_outputs()}, 32'd0);
    exp_q.push_back(sig(0, 8'h16, 1'b0, 1'b0));
    reset = 0;
    last_end = cyc;

    applyStimulus(1, 8'h03, 0, 0, 0);
    applyStimulus(1, 8'h1D, 2, 0, 0);
    applyStimulus(1, 8'h9D, 0, 0, 0);
    applyStimulus(1, 8'h79, 1, 0, 0);
    applyStimulus(1, 8'h2D, 0, 0, 0);
    applyStimulus(1, 8'h7B, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(1, 8'h05, T - 1, 0, 0);
    applyStimulus(1, 8'h1D, 0, 1, 0);
    applyStimulus(1, 8'h7D, 0, 0, 0);
    applyStimulus(1, 8'h20, 3, 1, 0);
    applyStimulus(1, 8'h77, 0, 0, 0);

    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: d = 8'h79;
        1: d = 8'h7B;
        2: d = 8'h7D;
        3: d = 8'h77;
        default: d = 8'($urandom_range(0, 255));
      endcase
      applyStimulus($urandom_range(0, 9) != 0, d,
                    ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 6),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    wait_cmd(got);
    @(negedge clk);
    exp_q.delete();
    reset = 1;
    #1;
    checkOutput("reset_in_wait", {1'b0, all_outputs()}, 32'd0);
    rsp_data = 8'h1D;
    rsp_strobe = 1;
    repeat (2) @(negedge clk);
    rsp_strobe = 0;
    model_reset();
    exp_q.push_back(sig(0, 8'h16, 1'b0, 1'b0));
    reset = 0;
    last_end = cyc;
    applyStimulus(1, 8'h07, 0, 0, 1);
    applyStimulus(1, 8'h1D, 0, 0, 0);

    wait_cmd(got);
    #1;
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
